// File: rtl/mem_access_unit.sv
// Load/store front-end to a word-aligned data memory: extracts and extends
// sub-word loads, and turns sub-word stores into a two-cycle read-modify-write.
module mem_access_unit #(
  parameter int ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        err_flag,
  output logic [31:0] err_addr,
  input  logic        err_clr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        dbg_merge,
  output logic        dbg_addr_oor
);

  typedef enum logic {S_IDLE, S_MERGE} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_word_q, hold_word_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [1:0]  hold_size_q, hold_size_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic        err_flag_q, err_flag_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        aligned;
  logic        set_err;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Lane selection for loads; size 1x is a full word.
  always_comb begin
    load_byte = mem_rdata[{addr[1:0], 3'b000} +: 8];
    load_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (size[1]) begin
      load_val = mem_rdata;
    end else if (size[0]) begin
      load_val = {{16{sign_ext & load_half[15]}}, load_half};
    end else begin
      load_val = {{24{sign_ext & load_byte[7]}}, load_byte};
    end
  end

  always_comb begin
    merged = hold_word_q;
    if (hold_size_q == 2'b01) begin
      if (hold_addr_q[1]) merged[31:16] = hold_data_q;
      else                merged[15:0]  = hold_data_q;
    end else begin
      merged[{hold_addr_q[1:0], 3'b000} +: 8] = hold_data_q[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_word_d = hold_word_q;
    hold_addr_d = hold_addr_q;
    hold_size_d = hold_size_q;
    hold_data_d = hold_data_q;
    rdata       = 32'h0;
    stall       = 1'b0;
    misalign    = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = {addr[31:2], 2'b00};
    mem_wdata   = 32'h0;
    set_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!aligned) begin
            misalign = 1'b1;
            set_err  = 1'b1;
          end else if (!we) begin
            mem_rd = 1'b1;
            rdata  = load_val;
          end else if (size[1]) begin
            mem_wr    = 1'b1;
            mem_wdata = wdata;
          end else begin
            // Sub-word store: read the word now, write the merged word next cycle.
            mem_rd      = 1'b1;
            stall       = 1'b1;
            hold_word_d = mem_rdata;
            hold_addr_d = addr;
            hold_size_d = size;
            hold_data_d = wdata[15:0];
            state_d     = S_MERGE;
          end
        end
      end
      S_MERGE: begin
        mem_wr    = 1'b1;
        mem_addr  = {hold_addr_q[31:2], 2'b00};
        mem_wdata = merged;
        state_d   = S_IDLE;
      end
    endcase
    if (reset) begin
      rdata    = 32'h0;
      stall    = 1'b0;
      misalign = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
    end
  end

  // A new misaligned request outranks a simultaneous clear.
  always_comb begin
    err_flag_d = set_err ? 1'b1 : (err_clr ? 1'b0 : err_flag_q);
    err_addr_d = set_err ? addr : err_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_word_q <= 32'h0;
      hold_addr_q <= 32'h0;
      hold_size_q <= 2'b00;
      hold_data_q <= 16'h0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      hold_word_q <= hold_word_d;
      hold_addr_q <= hold_addr_d;
      hold_size_q <= hold_size_d;
      hold_data_q <= hold_data_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_flag     = err_flag_q;
  assign err_addr     = err_addr_q;
  assign dbg_merge    = (state_q == S_MERGE);
  assign dbg_addr_oor = (addr >= 32'(ADDR_LIMIT));

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory model, per-cycle
// output comparison, and literal expectations from hand-worked examples.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, req, we, sign_ext, err_clr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, err_addr, mem_addr, mem_wdata, mem_rdata;
  logic        stall, misalign, err_flag, mem_rd, mem_wr, dbg_merge, dbg_addr_oor;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_LIMIT(1024)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
    .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_merge(dbg_merge), .dbg_addr_oor(dbg_addr_oor)
  );

  // Physical memory seen by the DUT.
  logic [31:0] phys [0:255];
  assign mem_rdata = (mem_addr < 32'd1024) ? phys[mem_addr[9:2]] : 32'h0;
  always @(posedge clk) if (mem_wr && mem_addr < 32'd1024) phys[mem_addr[9:2]] <= mem_wdata;

  // Reference model: byte-addressed memory and error state.
  logic [7:0]  rb [0:1023];
  logic        m_err;
  logic [31:0] m_err_addr;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        exp_rd, exp_wr, exp_stall, exp_mis, exp_merge;
  logic [31:0] exp_rdata, exp_maddr, exp_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit aligned_m(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic logic [31:0] load_m(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(rb[int'(a) + i]) << (8 * i));
    if (sx && n < 4 && rb[int'(a) + n - 1][7]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] word_m(input logic [31:0] a);
    return load_m(a & ~32'd3, 2'b10, 1'b0);
  endfunction

  task automatic store_m(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) rb[int'(a) + i] = wd[8 * i +: 8];
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] word);
    phys[a[9:2]] = word;
    for (int i = 0; i < 4; i++) rb[int'(a) + i] = word[8 * i +: 8];
  endtask

  task automatic set_idle();
    req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_merge = 1'b0;
    exp_rdata = 32'h0; exp_maddr = 32'h0; exp_wdata = 32'h0;
  endtask

  // Every cycle: strobes, stall, misalign, rdata and error state against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_rd", 32'(mem_rd), 32'(exp_rd));
      check("mem_wr", 32'(mem_wr), 32'(exp_wr));
      check("stall", 32'(stall), 32'(exp_stall));
      check("misalign", 32'(misalign), 32'(exp_mis));
      check("rdata", rdata, exp_rdata);
      check("err_flag", 32'(err_flag), 32'(m_err));
      check("err_addr", err_addr, m_err_addr);
      check("dbg_merge", 32'(dbg_merge), 32'(exp_merge));
      check("dbg_addr_oor", 32'(dbg_addr_oor), 32'(addr >= 32'd1024));
      if (exp_rd || exp_wr) check("mem_addr", mem_addr, exp_maddr);
      if (exp_wr) check("mem_wdata", mem_wdata, exp_wdata);
    end
  end

  // One request; sub-word stores also run their merge cycle (or abort it with reset).
  task automatic access(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] wd, input logic has_lit, input logic [31:0] lit,
                        input logic abort);
    int n;
    bit ok;
    n  = nbytes(sz);
    ok = aligned_m(sz, a);
    set_idle();
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    exp_maddr = a & ~32'd3;
    if (!ok) exp_mis = 1'b1;
    else if (!w) begin
      exp_rd = 1'b1;
      exp_rdata = load_m(a, sz, sx);
    end else if (n == 4) begin
      exp_wr = 1'b1;
      exp_wdata = wd;
      store_m(a, sz, wd);
    end else begin
      exp_rd = 1'b1;
      exp_stall = 1'b1;
    end
    if (has_lit && !w) begin
      #1;
      check("lit_rdata", rdata, lit);
    end
    @(posedge clk);
    if (!ok) begin
      m_err = 1'b1;
      m_err_addr = a;
    end else if (err_clr) m_err = 1'b0;
    #1;
    if (ok && w && n < 4) begin
      set_idle();
      if (abort) begin
        reset = 1'b1;
        m_err = 1'b0;
        m_err_addr = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end else begin
        // Inputs during the merge cycle must be ignored, even a misaligned request.
        req = 1'b1; we = 1'b0; size = 2'b01; addr = 32'h13;
        exp_wr = 1'b1; exp_merge = 1'b1; exp_maddr = a & ~32'd3;
        store_m(a, sz, wd);
        exp_wdata = word_m(a);
        if (has_lit) begin
          #1;
          check("lit_mem_wdata", mem_wdata, lit);
        end
        @(posedge clk);
        if (err_clr) m_err = 1'b0;
        #1;
      end
    end
    set_idle();
  endtask

  task automatic idle();
    set_idle();
    @(posedge clk);
    if (err_clr) m_err = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    err_clr = 1'b0;
    set_idle();
    m_err = 1'b0;
    m_err_addr = 32'h0;
    for (int i = 0; i < 256; i++) phys[i] = 32'h0;
    for (int i = 0; i < 1024; i++) rb[i] = 8'h0;
    chk_en = 1'b1;
    #2;
    check("reset_rdata", rdata, 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_err_flag", 32'(err_flag), 32'h0);
    check("reset_err_addr", err_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle();

    // Word store then word load.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hAABBCCDD, 1'b0);

    // Byte and halfword read-modify-write.
    preload(32'h10, 32'h11223344);
    access(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000EE, 1'b1, 32'h11EE3344, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11EE3344, 1'b0);
    preload(32'h10, 32'h11223344);
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 1'b1, 32'hBEEF3344, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hBEEF3344, 1'b0);

    // Signed and unsigned extraction.
    preload(32'h20, 32'h80FF7F01);
    access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b1, 32'h0000007F, 1'b0);
    access(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
    access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1, 32'h000080FF, 1'b0);
    access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0);
    access(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b1, 32'h00000080, 1'b0);
    access(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b1, 32'h00007F01, 1'b0);
    access(1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 1'b1, 32'h80FF7F01, 1'b0);

    // Misalignment, sticky flag, clear-versus-set priority.
    access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b0);
    check("lit_err_flag_set", 32'(err_flag), 32'h1);
    check("lit_err_addr_13", err_addr, 32'h13);
    err_clr = 1'b1;
    access(1'b1, 2'b10, 1'b0, 32'h22, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    err_clr = 1'b0;
    check("lit_err_flag_set_wins", 32'(err_flag), 32'h1);
    check("lit_err_addr_22", err_addr, 32'h22);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    check("lit_err_flag_cleared", 32'(err_flag), 32'h0);
    check("lit_err_addr_kept", err_addr, 32'h22);

    // Reset during the merge cycle abandons the write.
    preload(32'h30, 32'hCAFEF00D);
    access(1'b1, 2'b00, 1'b0, 32'h31, 32'h00000099, 1'b0, 32'h0, 1'b1);
    access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
    access(1'b1, 2'b00, 1'b0, 32'h33, 32'h00000055, 1'b1, 32'h55FEF00D, 1'b0);
    access(1'b1, 2'b00, 1'b0, 32'h30, 32'h12345677, 1'b1, 32'h55FEF077, 1'b0);
    access(1'b1, 2'b01, 1'b0, 32'h30, 32'hFFFFA5A5, 1'b1, 32'h55FEA5A5, 1'b0);
    access(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 1'b1, 32'h00000055, 1'b0);

    // More misaligned forms, then traffic near the top of memory.
    access(1'b0, 2'b10, 1'b0, 32'h26, 32'h0, 1'b1, 32'h0, 1'b0);
    access(1'b1, 2'b01, 1'b0, 32'h31, 32'h00001234, 1'b0, 32'h0, 1'b0);
    check("lit_err_addr_31", err_addr, 32'h31);
    access(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
    access(1'b1, 2'b01, 1'b0, 32'h3FE, 32'h00009876, 1'b1, 32'h98760BAD & 32'hFFFF0000 | 32'h0000F00D, 1'b0);
    access(1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 1'b1, 32'hFFFF9876, 1'b0);
    idle();

    chk_en = 1'b0;
    for (int w = 0; w < 256; w++) check($sformatf("mem_word_%0d", w), phys[w], word_m(32'(w * 4)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
